// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Package     : countdown_pkg
// Description : Shared types and constants for the BCD countdown timer:
//               FSM state encoding, BCD digit type and digit maxima.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;

endpackage : countdown_pkg
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : One BCD digit of a down-counting chain. Loads a preset
//               (clamped to MAX) and decrements on borrow-in, wrapping
//               0 -> MAX and raising borrow_out in that case.
// Ports       : clk        in  system clock
//               rst        in  asynchronous active-high reset (q -> 0)
//               load       in  copy clamped load_val into q
//               load_val   in  preset digit
//               dec_en     in  borrow-in / decrement enable
//               q          out current digit value
//               borrow_out out dec_en && q == 0
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow_out
);

  bcd_t w_load_clamped;

  assign w_load_clamped = (load_val > MAX) ? MAX : load_val;
  assign borrow_out     = dec_en && (q == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= w_load_clamped;
    end else if (dec_en) begin
      q <= (q == 4'd0) ? MAX : (q - 4'd1);
    end
  end

endmodule : bcd_down_digit
`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_countdown_timer
// Description : mm:ss.cc countdown timer. Loads a preset, decrements once per
//               centisecond tick while running and stops at 00:00.00.
// Ports       : clk, rst                       clock, async active-high reset
//               load, start, stop              level controls (load>stop>start)
//               preset_min_t..preset_cen       preset digits (clamped on load)
//               min_t..centesimas              current count, BCD
//               running                        high while in RUN
//               done                           one-cycle pulse on reaching zero
//               expired                        high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int TICK_W   = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset_min_t,
  input  logic [3:0] preset_min_u,
  input  logic [3:0] preset_sec_t,
  input  logic [3:0] preset_sec_u,
  input  logic [3:0] preset_dec,
  input  logic [3:0] preset_cen,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic [3:0] decimas,
  output logic [3:0] centesimas,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [TICK_W-1:0] r_presc;
  logic              w_tick;
  logic              w_load;
  logic              w_dec;
  logic              w_presc_clr;
  logic              w_done_next;
  logic              w_is_zero;
  logic              w_at_one;

  // Digit index 0 = centesimas ... 5 = min_t; borrow ripples upward.
  bcd_t              w_preset [6];
  bcd_t              w_q      [6];
  logic [6:0]        w_borrow;
  logic              w_unused_borrow;

  assign w_preset[0] = preset_cen;
  assign w_preset[1] = preset_dec;
  assign w_preset[2] = preset_sec_u;
  assign w_preset[3] = preset_sec_t;
  assign w_preset[4] = preset_min_u;
  assign w_preset[5] = preset_min_t;

  assign w_borrow[0] = w_dec;
  // Borrow out of min_t would mean underflow past zero, which the zero
  // detection prevents; it is intentionally left unused.
  assign w_unused_borrow = w_borrow[6];

  for (genvar i = 0; i < 6; i++) begin : g_digit
    bcd_down_digit #(
      .MAX ((i == 3) ? SEC_T_MAX : DIGIT_MAX)
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (w_load),
      .load_val   (w_preset[i]),
      .dec_en     (w_borrow[i]),
      .q          (w_q[i]),
      .borrow_out (w_borrow[i+1])
    );
  end

  assign centesimas = w_q[0];
  assign decimas    = w_q[1];
  assign sec_u      = w_q[2];
  assign sec_t      = w_q[3];
  assign min_u      = w_q[4];
  assign min_t      = w_q[5];

  assign w_is_zero = (w_q[0] == 4'd0) && (w_q[1] == 4'd0) && (w_q[2] == 4'd0) &&
                     (w_q[3] == 4'd0) && (w_q[4] == 4'd0) && (w_q[5] == 4'd0);
  // 00:00.01 is the only value a single tick turns into zero.
  assign w_at_one  = (w_q[0] == 4'd1) && (w_q[1] == 4'd0) && (w_q[2] == 4'd0) &&
                     (w_q[3] == 4'd0) && (w_q[4] == 4'd0) && (w_q[5] == 4'd0);

  assign w_tick = (r_state == RUN) && (r_presc == c_TICK_LAST);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_presc_clr  = 1'b0;
    w_done_next  = 1'b0;
    if (load && (r_state != RUN)) begin
      w_load       = 1'b1;
      w_state_next = IDLE;
    end else begin
      case (r_state)
        RUN: begin
          // Stop discards a coincident tick.
          if (stop) begin
            w_state_next = PAUSE;
          end else if (w_tick) begin
            w_dec = 1'b1;
            if (w_at_one) begin
              w_state_next = DONE;
              w_done_next  = 1'b1;
            end
          end
        end
        IDLE, PAUSE: begin
          if (!stop && start) begin
            if (w_is_zero) begin
              w_state_next = DONE;
              w_done_next  = 1'b1;
            end else begin
              w_state_next = RUN;
              w_presc_clr  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      r_state <= w_state_next;
      running <= (w_state_next == RUN);
      done    <= w_done_next;
      expired <= (w_state_next == DONE);
    end
  end

  // Prescaler holds while paused and restarts from zero on (re)entry to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_presc_clr) begin
      r_presc <= '0;
    end else if ((r_state == RUN) && !stop) begin
      r_presc <= w_tick ? '0 : (r_presc + TICK_W'(1));
    end
  end

endmodule : bcd_countdown_timer
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_countdown_timer
// Description : Self-checking bench for bcd_countdown_timer with TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] preset = 24'h0;
  logic [3:0]  min_t, min_u, sec_t, sec_u, decimas, centesimas;
  logic        running, done, expired;
  logic [23:0] cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic        sp;
    logic [23:0] pre;
    logic [23:0] exp_cnt;
    logic        exp_run;
    logic        exp_done;
    logic        exp_expired;
  } vec_t;

  vec_t vecs [20];

  always #5 clk = ~clk;

  assign cnt = {min_t, min_u, sec_t, sec_u, decimas, centesimas};

  bcd_countdown_timer #(
    .TICK_DIV (4),
    .TICK_W   (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .start        (start),
    .stop         (stop),
    .preset_min_t (preset[23:20]),
    .preset_min_u (preset[19:16]),
    .preset_sec_t (preset[15:12]),
    .preset_sec_u (preset[11:8]),
    .preset_dec   (preset[7:4]),
    .preset_cen   (preset[3:0]),
    .min_t        (min_t),
    .min_u        (min_u),
    .sec_t        (sec_t),
    .sec_u        (sec_u),
    .decimas      (decimas),
    .centesimas   (centesimas),
    .running      (running),
    .done         (done),
    .expired      (expired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] ec,
                       input logic er, input logic ed, input logic ee);
    checks++;
    if ({cnt, running, done, expired} !== {ec, er, ed, ee}) begin
      failures++;
      $display("FAIL %s: got cnt=%h run=%b done=%b exp=%b, want cnt=%h run=%b done=%b exp=%b",
               name, cnt, running, done, expired, ec, er, ed, ee);
    end
  endtask

  initial begin
    // Basic countdown from 00:00.03, start in DONE, clamping, zero start.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'h000003, 24'h000003, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000003, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000003, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000003, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000003, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000002, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000002, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000002, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000002, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000001, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000001, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000001, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000001, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 24'h00700C, 24'h005009, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) step();
    check("reset_held", 24'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check("reset_idle", 24'h0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      load   = vecs[i].ld;
      start  = vecs[i].st;
      stop   = vecs[i].sp;
      preset = vecs[i].pre;
      step();
      check($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_run,
            vecs[i].exp_done, vecs[i].exp_expired);
    end
    load = 1'b0; start = 1'b0; stop = 1'b0;

    // Borrow chain 01:00.00 -> 00:59.99
    load = 1'b1; preset = 24'h010000;
    step(); load = 1'b0;
    check("brw_load", 24'h010000, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step(); start = 1'b0;
    check("brw_run", 24'h010000, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check("brw_pre", 24'h010000, 1'b1, 1'b0, 1'b0);
    step();
    check("brw_tick", 24'h005999, 1'b1, 1'b0, 1'b0);

    // Pause and resume at 00:05.00
    stop = 1'b1;
    step();
    check("brw_stop", 24'h005999, 1'b0, 1'b0, 1'b0);
    load = 1'b1; preset = 24'h000500;
    step(); load = 1'b0; stop = 1'b0;
    check("pz_load", 24'h000500, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step(); start = 1'b0;
    check("pz_run", 24'h000500, 1'b1, 1'b0, 1'b0);
    repeat (2) step();
    stop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("pz_hold%0d", i), 24'h000500, 1'b0, 1'b0, 1'b0);
    end
    stop = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    check("pz_resume", 24'h000500, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check("pz_pre", 24'h000500, 1'b1, 1'b0, 1'b0);
    step();
    check("pz_tick", 24'h000499, 1'b1, 1'b0, 1'b0);

    // Priority: load > stop > start in PAUSE, load ignored in RUN
    stop = 1'b1;
    step(); stop = 1'b0;
    check("pri_pause_in", 24'h000499, 1'b0, 1'b0, 1'b0);
    load = 1'b1; stop = 1'b1; start = 1'b1; preset = 24'h001234;
    step(); load = 1'b0; stop = 1'b0; start = 1'b0;
    check("pri_pause", 24'h001234, 1'b0, 1'b0, 1'b0);
    step();
    check("pri_idle", 24'h001234, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step(); start = 1'b0;
    check("pri_run", 24'h001234, 1'b1, 1'b0, 1'b0);
    load = 1'b1; preset = 24'h009999;
    step(); load = 1'b0;
    check("pri_runload", 24'h001234, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check("pri_tick", 24'h001233, 1'b1, 1'b0, 1'b0);

    // Stop in the same cycle as a tick: the decrement is discarded
    repeat (3) step();
    stop = 1'b1;
    step(); stop = 1'b0;
    check("stop_vs_tick", 24'h001233, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during RUN at 00:30.00
    load = 1'b1; preset = 24'h003000;
    step(); load = 1'b0;
    start = 1'b1;
    step(); start = 1'b0;
    repeat (2) step();
    check("ar_run", 24'h003000, 1'b1, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("ar_async", 24'h000000, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("ar_idle", 24'h000000, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step(); start = 1'b0;
    check("ar_zero_start", 24'h000000, 1'b0, 1'b1, 1'b1);
    step();
    check("ar_done_level", 24'h000000, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bcd_countdown_timer
`default_nettype wire
